// File: rtl/hamming_enc_arbiter_if.sv
// Bundle of requester, encoder and output-stream signals for hamming_enc_arbiter.
// The master view belongs to the arbiter; the slave view belongs to its surroundings.
interface hamming_enc_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [7*NREQ-1:0] req_data;
  logic [6:0]        enc_data;
  logic [10:0]       enc_code;
  logic              out_valid;
  logic              out_ready;
  logic [10:0]       out_code;
  logic [ID_W-1:0]   out_id;
  logic              busy;

  modport master (
    input  req_valid, req_data, enc_code, out_ready,
    output req_ready, enc_data, out_valid, out_code, out_id, busy
  );

  modport slave (
    output req_valid, req_data, enc_code, out_ready,
    input  req_ready, enc_data, out_valid, out_code, out_id, busy
  );
endinterface

// File: rtl/hamming_enc_arbiter.sv
// Shares one external registered Hamming(11,7) encoder among NREQ valid/ready requesters.
// Round-robin by default; define HAMENC_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module hamming_enc_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned ENC_LAT = 1
) (
  input logic                   clk,
  input logic                   rst,
  hamming_enc_arbiter_if.master bus
);

  if (NREQ < 2 || NREQ > (1 << ID_W)) begin : g_bad_nreq
    $error("hamming_enc_arbiter: NREQ must lie in 2..2**ID_W");
  end
  if (ENC_LAT < 1 || ENC_LAT > 7) begin : g_bad_lat
    $error("hamming_enc_arbiter: ENC_LAT must lie in 1..7");
  end

  localparam logic [2:0] EncLatCnt = 3'(ENC_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StEnc,
    StOut
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [6:0]      enc_data_q, enc_data_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            out_valid_q, out_valid_d;
  logic [10:0]     out_code_q, out_code_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [NREQ-1:0] req_ready;

  logic [NREQ-1:0] gnt_oh;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic [6:0]      gnt_data;

`ifdef HAMENC_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest asserted index is the last (winning) assignment.
  always_comb begin
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_id    = ID_W'(i);
        gnt_any   = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] last_q;

  // Search starts one past the previous winner and wraps around.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = (int'(last_q) + k) % int'(NREQ);
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!gnt_any && i == cand && bus.req_valid[i]) begin
          gnt_oh[i] = 1'b1;
          gnt_id    = ID_W'(i);
          gnt_any   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_W'(NREQ - 1);
    end else if (state_q == StIdle && gnt_any) begin
      last_q <= gnt_id;
    end
  end
`endif

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_oh[i]) begin
        gnt_data = bus.req_data[7*i +: 7];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enc_data_d  = enc_data_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_id_d    = out_id_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          req_ready  = gnt_oh;
          enc_data_d = gnt_data;
          id_d       = gnt_id;
          cnt_d      = '0;
          state_d    = StEnc;
        end
      end
      StEnc: begin
        // enc_data stays put; the encoder output is valid once cnt reaches the latency.
        if (cnt_q == EncLatCnt) begin
          out_code_d  = bus.enc_code;
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      enc_data_q  <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      enc_data_q  <= enc_data_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.enc_data  = enc_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = (state_q != StIdle);

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_code) && $stable(bus.out_id)));
`endif

endmodule
